// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 16;
    localparam int NREGS_DEF = 8;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]          xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an in-flight writer.
// Priority per register: flush clears, then issue sets, then writeback clears.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_en_i,
    input  logic [AW-1:0]        issue_rd_i,
    input  logic                 flush_i,
    input  logic                 clr0_en_i,
    input  logic [AW-1:0]        clr0_addr_i,
    input  logic                 clr1_en_i,
    input  logic [AW-1:0]        clr1_addr_i,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]    busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (issue_en_i && (issue_rd_i == AW'(r))) begin
                // A new producer supersedes a same-cycle writeback of the old one.
                busy_d[r] = 1'b1;
            end else if ((clr0_en_i && (clr0_addr_i == AW'(r))) ||
                         (clr1_en_i && (clr1_addr_i == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, two write ports (port 1 wins on conflict), r0 hardwired to zero.
// Optional write-through bypass on read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we0_i,
    input  logic [AW-1:0]          wa0_i,
    input  logic [XLEN-1:0]        wd0_i,
    input  logic                   we1_i,
    input  logic [AW-1:0]          wa1_i,
    input  logic [XLEN-1:0]        wd1_i,
    input  logic [NUM_RD*AW-1:0]   rs_addr_i,
    output logic [NUM_RD*XLEN-1:0] rs_data_o,
    output logic [NUM_RD-1:0]      rs_busy_o,
    input  logic                   issue_en_i,
    input  logic [AW-1:0]          issue_rd_i,
    input  logic                   flush_i
);

    logic [XLEN-1:0]   mem_q [NREGS];
    logic [XLEN-1:0]   mem_d [NREGS];
    logic [NUM_RD-1:0] sb_busy;

    always_comb begin
        mem_d = mem_q;
        for (int r = 1; r < NREGS; r++) begin
            if (we1_i && (wa1_i == AW'(r))) begin
                mem_d[r] = wd1_i;
            end else if (we0_i && (wa0_i == AW'(r))) begin
                mem_d[r] = wd0_i;
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en_i  (issue_en_i),
        .issue_rd_i  (issue_rd_i),
        .flush_i     (flush_i),
        .clr0_en_i   (we0_i),
        .clr0_addr_i (wa0_i),
        .clr1_en_i   (we1_i),
        .clr1_addr_i (wa1_i),
        .rd_addr_i   (rs_addr_i),
        .busy_o      (sb_busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rs_addr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic hit0;
        logic hit1;
        logic issue_hit;
        assign hit0      = we0_i && (wa0_i == ra) && (ra != '0);
        assign hit1      = we1_i && (wa1_i == ra) && (ra != '0);
        assign issue_hit = issue_en_i && !flush_i && (issue_rd_i == ra);
        assign rs_data_o[k*XLEN +: XLEN] = hit1 ? wd1_i : (hit0 ? wd0_i : mem_q[ra]);
        // A same-cycle writeback hides busy unless a new producer is issuing now.
        assign rs_busy_o[k] = ((hit0 || hit1) && !issue_hit) ? 1'b0 : sb_busy[k];
`else
        assign rs_data_o[k*XLEN +: XLEN] = mem_q[ra];
        assign rs_busy_o[k] = sb_busy[k];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    localparam int XLEN   = 16;
    localparam int NREGS  = 8;
    localparam int NUM_RD = 2;
    localparam int AW     = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   we0_i, we1_i, issue_en_i, flush_i;
    logic [AW-1:0]          wa0_i, wa1_i, issue_rd_i;
    logic [XLEN-1:0]        wd0_i, wd1_i;
    logic [NUM_RD*AW-1:0]   rs_addr_i;
    logic [NUM_RD*XLEN-1:0] rs_data_o;
    logic [NUM_RD-1:0]      rs_busy_o;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we0_i      (we0_i),
        .wa0_i      (wa0_i),
        .wd0_i      (wd0_i),
        .we1_i      (we1_i),
        .wa1_i      (wa1_i),
        .wd1_i      (wd1_i),
        .rs_addr_i  (rs_addr_i),
        .rs_data_o  (rs_data_o),
        .rs_busy_o  (rs_busy_o),
        .issue_en_i (issue_en_i),
        .issue_rd_i (issue_rd_i),
        .flush_i    (flush_i)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] m_mem [NREGS];
    logic            m_busy [NREGS];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic idle();
        we0_i = 0; wa0_i = 0; wd0_i = 0;
        we1_i = 0; wa1_i = 0; wd1_i = 0;
        issue_en_i = 0; issue_rd_i = 0; flush_i = 0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rs_addr_i[k*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] rd_addr(input int k);
        return rs_addr_i[k*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we1_i && wa1_i == a) return wd1_i;
        if (we0_i && wa0_i == a) return wd0_i;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((we0_i && wa0_i == a) || (we1_i && wa1_i == a)) &&
            !(issue_en_i && !flush_i && issue_rd_i == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic check_ports(input string tag);
        for (int k = 0; k < NUM_RD; k++) begin
            chk($sformatf("%s_data%0d_r%0d", tag, k, rd_addr(k)),
                32'(rs_data_o[k*XLEN +: XLEN]), 32'(exp_data(rd_addr(k))));
            chk($sformatf("%s_busy%0d_r%0d", tag, k, rd_addr(k)),
                32'(rs_busy_o[k]), 32'(exp_busy(rd_addr(k))));
        end
    endtask

    // Advance one edge; the model applies writes in port order so port 1 lands last,
    // then retires writebacks before marking the issued destination.
    task automatic tick();
        @(posedge clk);
        if (we0_i && wa0_i != 0) m_mem[wa0_i] = wd0_i;
        if (we1_i && wa1_i != 0) m_mem[wa1_i] = wd1_i;
        if (flush_i) begin
            for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
        end else begin
            if (we0_i) m_busy[wa0_i] = 1'b0;
            if (we1_i) m_busy[wa1_i] = 1'b0;
            if (issue_en_i) m_busy[issue_rd_i] = 1'b1;
        end
        m_busy[0] = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        rs_addr_i = '0;
        model_reset();
        #12;
        for (int a = 1; a < NREGS; a += 3) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(a + 1));
            #1;
            chk("reset_data0", 32'(rs_data_o[0 +: XLEN]), 32'h0);
            chk("reset_busy", 32'(rs_busy_o), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset discards a stored value and busy bit without an edge.
        we0_i = 1; wa0_i = 3; wd0_i = 16'h1234; issue_en_i = 1; issue_rd_i = 3;
        tick();
        idle();
        set_rd(0, 3); set_rd(1, 3);
        #1;
        chk("t1_pre_data", 32'(rs_data_o[0 +: XLEN]), 32'h1234);
        chk("t1_pre_busy", 32'(rs_busy_o), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_data", 32'(rs_data_o), 32'h0);
        chk("t1_rst_busy", 32'(rs_busy_o), 32'h0);
        model_reset();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Same-address dual write: load port wins. r0 ignores writes.
        we0_i = 1; wa0_i = 5; wd0_i = 16'h00AA;
        we1_i = 1; wa1_i = 5; wd1_i = 16'h0BBB;
        tick();
        idle();
        set_rd(0, 5); set_rd(1, 0);
        #1;
        chk("t2_r5", 32'(rs_data_o[0 +: XLEN]), 32'h0BBB);
        we0_i = 1; wa0_i = 0; wd0_i = 16'hFFFF;
        tick();
        idle();
        #1;
        chk("t2_r0_data", 32'(rs_data_o[XLEN +: XLEN]), 32'h0);
        chk("t2_r0_busy", 32'(rs_busy_o[1]), 32'h0);

        // Issue then writeback clears busy one edge later.
        issue_en_i = 1; issue_rd_i = 2;
        set_rd(1, 2);
        #1;
        chk("t3_busy_before_edge", 32'(rs_busy_o[1]), 32'h0);
        tick();
        idle();
        #1;
        chk("t3_busy_set", 32'(rs_busy_o[1]), 32'h1);
        we0_i = 1; wa0_i = 2; wd0_i = 16'h0042;
        #1;
        check_ports("t3_wb_cycle");
        tick();
        idle();
        #1;
        chk("t3_busy_clr", 32'(rs_busy_o[1]), 32'h0);
        chk("t3_data", 32'(rs_data_o[XLEN +: XLEN]), 32'h0042);

        // Issue wins over same-cycle writeback clear.
        issue_en_i = 1; issue_rd_i = 4;
        tick();
        issue_en_i = 1; issue_rd_i = 4;
        we1_i = 1; wa1_i = 4; wd1_i = 16'h0007;
        tick();
        idle();
        set_rd(0, 4);
        #1;
        chk("t4_busy", 32'(rs_busy_o[0]), 32'h1);
        chk("t4_data", 32'(rs_data_o[0 +: XLEN]), 32'h0007);

        // Flush clears everything, drops same-cycle issue, but still writes data.
        issue_en_i = 1; issue_rd_i = 1; tick();
        issue_rd_i = 6; tick();
        issue_rd_i = 7; tick();
        idle();
        set_rd(0, 1); set_rd(1, 6);
        #1;
        chk("t5_busy_r1_r6", 32'(rs_busy_o), 32'h3);
        flush_i = 1; issue_en_i = 1; issue_rd_i = 3;
        we0_i = 1; wa0_i = 6; wd0_i = 16'h0055;
        tick();
        idle();
        for (int a = 1; a < NREGS; a++) begin
            set_rd(0, AW'(a));
            #1;
            chk($sformatf("t5_busy_r%0d", a), 32'(rs_busy_o[0]), 32'h0);
        end
        set_rd(1, 6);
        #1;
        chk("t5_r6_data", 32'(rs_data_o[XLEN +: XLEN]), 32'h0055);

        // Same-cycle read of a register being written.
        we0_i = 1; wa0_i = 3; wd0_i = 16'h0ABC;
        tick();
        idle();
        set_rd(1, 3);
        we0_i = 1; wa0_i = 3; wd0_i = 16'h1111;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t6_byp0", 32'(rs_data_o[XLEN +: XLEN]), 32'h1111);
`else
        chk("t6_byp0", 32'(rs_data_o[XLEN +: XLEN]), 32'h0ABC);
`endif
        we1_i = 1; wa1_i = 3; wd1_i = 16'h2222;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t6_byp1", 32'(rs_data_o[XLEN +: XLEN]), 32'h2222);
`else
        chk("t6_byp1", 32'(rs_data_o[XLEN +: XLEN]), 32'h0ABC);
`endif
        tick();
        idle();
        #1;
        chk("t6_after", 32'(rs_data_o[XLEN +: XLEN]), 32'h2222);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            we0_i      = 1'($urandom_range(0, 1));
            wa0_i      = AW'($urandom_range(0, NREGS - 1));
            wd0_i      = XLEN'($urandom);
            we1_i      = 1'($urandom_range(0, 1));
            wa1_i      = ($urandom_range(0, 3) == 0) ? wa0_i : AW'($urandom_range(0, NREGS - 1));
            wd1_i      = XLEN'($urandom);
            issue_en_i = 1'($urandom_range(0, 1));
            issue_rd_i = ($urandom_range(0, 3) == 0) ? wa1_i : AW'($urandom_range(0, NREGS - 1));
            flush_i    = ($urandom_range(0, 9) == 0);
            set_rd(0, AW'($urandom_range(0, NREGS - 1)));
            set_rd(1, ($urandom_range(0, 2) == 0) ? wa0_i : AW'($urandom_range(0, NREGS - 1)));
            #1;
            check_ports("rnd");
            tick();
        end
        idle();
        for (int a = 0; a < NREGS; a++) begin
            set_rd(0, AW'(a));
            #1;
            check_ports("final");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
